// File: rtl/cdb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cdb_issue_scheduler
// Brief    : Round-robin issue picker for INT/MULT/DIV/MEM queues that keeps
//            common-data-bus result slots conflict-free; tracks DIV occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_issue_scheduler #(
    parameter int INT_LAT  = 1,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8,
    parameter int MEM_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_ready,
    input  logic       mult_ready,
    input  logic       div_ready,
    input  logic       mem_ready,
    output logic       int_issue,
    output logic       mult_issue,
    output logic       div_issue,
    output logic       mem_issue,
    output logic [1:0] cdb_owner,
    output logic       cdb_owner_valid,
    output logic       div_busy
);

    localparam int D01  = (INT_LAT > MULT_LAT) ? INT_LAT : MULT_LAT;
    localparam int D23  = (DIV_LAT > MEM_LAT) ? DIV_LAT : MEM_LAT;
    localparam int D    = (D01 > D23) ? D01 : D23;
    localparam int IW   = $clog2(D + 1);
    localparam int CW   = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    // Entry k of the table describes the CDB k cycles from now.
    logic [D:0]      r_vld;
    logic [D:0][1:0] r_own;
    logic [1:0]      r_rr;
    logic [CW-1:0]   r_div_cnt;

    logic [3:0]      w_elig;
    logic [3:0]      w_rot;
    logic [1:0]      w_off;
    logic [1:0]      w_gidx;
    logic            w_found;
    logic [3:0]      w_grant;
    logic [IW-1:0]   w_tgt;

    always_comb begin
        w_elig[0] = int_ready  && !r_vld[INT_LAT];
        w_elig[1] = mult_ready && !r_vld[MULT_LAT];
        w_elig[2] = div_ready  && !r_vld[DIV_LAT] && (r_div_cnt == '0);
        w_elig[3] = mem_ready  && !r_vld[MEM_LAT];
    end

    // Rotate eligibility so bit 0 is the unit at the round-robin pointer.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < 4; j++) begin
            w_rot[j] = w_elig[r_rr + 2'(j)];
        end
    end

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end
        w_gidx  = r_rr + w_off;
        w_found = (|w_rot) && rst_n;
        w_grant = w_found ? (4'b0001 << w_gidx) : 4'b0000;
    end

    // The table shifts before the new reservation lands, hence LAT-1.
    always_comb begin
        case (w_gidx)
            2'd0:    w_tgt = IW'(INT_LAT - 1);
            2'd1:    w_tgt = IW'(MULT_LAT - 1);
            2'd2:    w_tgt = IW'(DIV_LAT - 1);
            default: w_tgt = IW'(MEM_LAT - 1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_own     <= '0;
            r_rr      <= 2'd0;
            r_div_cnt <= '0;
        end else begin
            r_vld <= {1'b0, r_vld[D:1]};
            r_own <= {2'b00, r_own[D:1]};
            if (w_found) begin
                r_vld[w_tgt] <= 1'b1;
                r_own[w_tgt] <= w_gidx;
                r_rr         <= w_gidx + 2'd1;
            end
            if (w_grant[2]) begin
                r_div_cnt <= CW'(DIV_LAT - 1);
            end else if (r_div_cnt != '0) begin
                r_div_cnt <= r_div_cnt - 1'b1;
            end
        end
    end

    assign int_issue       = w_grant[0];
    assign mult_issue      = w_grant[1];
    assign div_issue       = w_grant[2];
    assign mem_issue       = w_grant[3];
    assign cdb_owner       = r_own[0];
    assign cdb_owner_valid = r_vld[0];
    assign div_busy        = (r_div_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_cdb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_issue_scheduler
// Brief    : Bench for cdb_issue_scheduler against a CDB-booking model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_issue_scheduler;

    logic       clk;
    logic       rst_n;
    logic       int_ready, mult_ready, div_ready, mem_ready;
    logic       int_issue, mult_issue, div_issue, mem_issue;
    logic [1:0] cdb_owner;
    logic       cdb_owner_valid;
    logic       div_busy;

    cdb_issue_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .int_ready      (int_ready),
        .mult_ready     (mult_ready),
        .div_ready      (div_ready),
        .mem_ready      (mem_ready),
        .int_issue      (int_issue),
        .mult_issue     (mult_issue),
        .div_issue      (div_issue),
        .mem_issue      (mem_issue),
        .cdb_owner      (cdb_owner),
        .cdb_owner_valid(cdb_owner_valid),
        .div_busy       (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int lat [4] = '{1, 4, 8, 2};
    int booked [int];   // absolute cycle -> unit that owns the CDB then
    int rr_m;
    int last_div;

    logic [3:0] s_iss;
    logic       s_cv;
    logic [1:0] s_co;
    logic       s_bz;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        booked.delete();
        rr_m     = 0;
        last_div = -1000;
    endtask

    // One clock cycle: drive, check DUT against the model, advance the model.
    task automatic step(input logic [3:0] rdy, input logic rstv);
        int         g;
        int         u;
        logic [3:0] exp_iss;
        logic       exp_cv;
        logic       exp_bz;
        @(negedge clk);
        rst_n = rstv;
        {mem_ready, div_ready, mult_ready, int_ready} = rdy;
        #1;
        if (!rstv) model_clear();
        g = -1;
        if (rstv) begin
            for (int k = 0; k < 4; k++) begin
                u = (rr_m + k) % 4;
                if (g < 0 && rdy[u] && !booked.exists(cyc + lat[u]) &&
                    (u != 2 || cyc - last_div >= lat[2]))
                    g = u;
            end
        end
        exp_iss = (g < 0) ? 4'b0000 : (4'b0001 << g);
        exp_cv  = booked.exists(cyc);
        exp_bz  = (cyc - last_div >= 1) && (cyc - last_div < lat[2]);
        s_iss = {mem_issue, div_issue, mult_issue, int_issue};
        s_cv  = cdb_owner_valid;
        s_co  = cdb_owner;
        s_bz  = div_busy;
        chk("issue", 8'(s_iss), 8'(exp_iss));
        chk("issue_onehot0", 8'($onehot0(s_iss)), 8'd1);
        chk("cdb_valid", 8'(s_cv), 8'(exp_cv));
        if (exp_cv) chk("cdb_owner", 8'(s_co), 8'(booked[cyc]));
        chk("div_busy", 8'(s_bz), 8'(exp_bz));
        if (exp_cv) booked.delete(cyc);
        if (g >= 0) begin
            booked[cyc + lat[g]] = g;
            rr_m = (g + 1) % 4;
            if (g == 2) last_div = cyc;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        {mem_ready, div_ready, mult_ready, int_ready} = 4'b0000;
        model_clear();
        step(4'b1111, 1'b0);
        chk("reset_issue", 8'(s_iss), 8'h00);
        chk("reset_cdb_valid", 8'(s_cv), 8'h00);
        chk("reset_cdb_owner", 8'(s_co), 8'h00);
        chk("reset_div_busy", 8'(s_bz), 8'h00);
        step(4'b0000, 1'b0);

        // INT only: back-to-back issue, results one cycle later
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, 1'b1);
            chk("t1_int_issue", 8'(s_iss), 8'h01);
            if (i > 0) chk("t1_cdb", 8'({s_cv, s_co}), 8'h4);
        end
        step(4'b0000, 1'b1);
        chk("t1_cdb_last", 8'({s_cv, s_co}), 8'h4);
        idle(10);

        // MULT then MEM: MEM blocked one cycle by the MULT result slot
        step(4'b0010, 1'b1);
        chk("t2_mult_issue", 8'(s_iss), 8'h02);
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b1);
        chk("t2_mem_blocked", 8'(s_iss), 8'h00);
        step(4'b1000, 1'b1);
        chk("t2_mem_issue", 8'(s_iss), 8'h08);
        step(4'b0000, 1'b1);
        chk("t2_cdb_mult", 8'({s_cv, s_co}), 8'h5);
        step(4'b0000, 1'b1);
        chk("t2_cdb_mem", 8'({s_cv, s_co}), 8'h7);
        idle(10);

        // INT and MULT both held: alternation
        step(4'b0011, 1'b1);
        chk("t3_c0", 8'(s_iss), 8'h01);
        step(4'b0011, 1'b1);
        chk("t3_c1", 8'(s_iss), 8'h02);
        step(4'b0011, 1'b1);
        chk("t3_c2", 8'(s_iss), 8'h01);
        for (int i = 0; i < 5; i++) step(4'b0011, 1'b1);
        idle(10);

        // DIV held: one issue per DIV_LAT cycles
        for (int i = 0; i <= 16; i++) begin
            step(4'b0100, 1'b1);
            if (i == 0 || i == 8 || i == 16) chk("t4_div_issue", 8'(s_iss), 8'h04);
            if (i >= 1 && i <= 7) chk("t4_div_busy", 8'(s_bz), 8'h01);
            if (i == 8 || i == 16) chk("t4_cdb_div", 8'({s_cv, s_co}), 8'h6);
        end
        idle(12);

        // Reset mid-flight discards the MULT reservation and the pointer
        step(4'b0010, 1'b1);
        chk("t5_mult_issue", 8'(s_iss), 8'h02);
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b0);
        chk("t5_in_reset_issue", 8'(s_iss), 8'h00);
        chk("t5_in_reset_cdb", 8'({s_cv, s_co}), 8'h0);
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        chk("t5_cdb_dropped", 8'(s_cv), 8'h00);
        chk("t5_rr_from_int", 8'(s_iss), 8'h01);
        idle(10);

        // Random ready patterns, with a few resets sprinkled in
        for (int i = 0; i < 10000; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 999) != 0));
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
